// File: rtl/negedge_detector_pkg.sv
// Shared definitions for the edge detector.
//   edge_mode_e      : which transition produces a pulse
//   MAX_WIDTH        : largest supported lane count
//   MIN/MAX_SYNC_STAGES : legal synchronizer depths
//   ev()             : per-lane edge event from the previous and current samples
package negedge_detector_pkg;

    typedef enum logic [1:0] {
        EDGE_FALL = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_e;

    localparam int MAX_WIDTH       = 64;
    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;

    // Operates on the widest lane vector; callers extend and truncate.
    function automatic logic [MAX_WIDTH-1:0] ev(
        input logic [MAX_WIDTH-1:0] prev,
        input logic [MAX_WIDTH-1:0] cur,
        input edge_mode_e           mode
    );
        case (mode)
            EDGE_FALL: ev = prev & ~cur;
            EDGE_RISE: ev = ~prev & cur;
            EDGE_BOTH: ev = prev ^ cur;
            default:   ev = '0;
        endcase
    endfunction

endpackage

// File: rtl/edge_sync_chain.sv
// Multi-lane flop-chain synchronizer, cleared by synchronous reset.
//   clk : system clock
//   rst : synchronous active-high reset, clears every stage
//   d   : asynchronous lane inputs
//   q   : synchronized lane outputs, STAGES cycles behind d
module edge_sync_chain
    import negedge_detector_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = MIN_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/negedge_detector.sv
// Synchronous multi-lane edge detector with registered one-cycle pulses.
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   sig       : level inputs, one lane per bit
//   detection : registered edge pulse per lane
// Build option NEGEDGE_DETECTOR_SYNC_EN inserts a SYNC_STAGES-deep
// synchronizer ahead of the history register for asynchronous sources.
module negedge_detector
    import negedge_detector_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int EDGE_MODE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] detection
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("negedge_detector: WIDTH %0d out of range 1..%0d", WIDTH, MAX_WIDTH);
    end
    if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
        $error("negedge_detector: EDGE_MODE %0d must be 0, 1 or 2", EDGE_MODE);
    end
    if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
        $error("negedge_detector: SYNC_STAGES %0d out of range %0d..%0d",
               SYNC_STAGES, MIN_SYNC_STAGES, MAX_SYNC_STAGES);
    end

    localparam edge_mode_e MODE = edge_mode_e'(EDGE_MODE[1:0]);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] prev;

`ifdef NEGEDGE_DETECTOR_SYNC_EN
    edge_sync_chain #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sig),
        .q   (s)
    );
`else
    assign s = sig;
`endif

    // prev clears to 0 so a lane low at reset release never looks like a fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev      <= '0;
            detection <= '0;
        end else begin
            prev      <= s;
            detection <= WIDTH'(ev(MAX_WIDTH'(prev), MAX_WIDTH'(s), MODE));
        end
    end

endmodule

// File: tb/tb_negedge_detector.sv
module tb_negedge_detector;

    localparam int HMAX = 1024;
`ifdef NEGEDGE_DETECTOR_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] stim = 4'b0000;
    logic       sig1;
    logic       det1;
    logic [3:0] det4;

    assign sig1 = stim[0];

    always #5 clk = ~clk;

    negedge_detector dut1 (
        .clk       (clk),
        .rst       (rst),
        .sig       (sig1),
        .detection (det1)
    );

    negedge_detector #(.WIDTH(4), .EDGE_MODE(2), .SYNC_STAGES(2)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .sig       (stim),
        .detection (det4)
    );

    // Reference history: what was presented at each edge index.
    logic [3:0] sig_h [HMAX];
    bit         rst_h [HMAX];
    int         n_edges = 0;

    logic [0:0] q1 [$];
    logic [3:0] q4 [$];
    logic [0:0] e1;
    logic [3:0] e4;

    int checks = 0;
    int passed = 0;
    int pushed = 0;
    int popped = 0;
    int exp_pulses = 0;
    int act_pulses = 0;
    bit done = 0;

    // Value the history stage sees at edge n: the input LAT edges earlier,
    // or 0 if a reset intervened (or the edge predates the run).
    function automatic logic [3:0] seen_at(int n);
        if (n - LAT < 0) return 4'b0000;
        for (int k = n - LAT; k < n; k++)
            if (rst_h[k]) return 4'b0000;
        return sig_h[n - LAT];
    endfunction

    function automatic logic [3:0] expect_at(int n, int mode);
        logic [3:0] p, c;
        if (rst_h[n]) return 4'b0000;
        p = (n == 0 || rst_h[n-1]) ? 4'b0000 : seen_at(n - 1);
        c = seen_at(n);
        case (mode)
            0:       return p & ~c;
            1:       return ~p & c;
            default: return p ^ c;
        endcase
    endfunction

    task automatic check(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic step(bit r, logic [3:0] v);
        logic [3:0] x;
        @(negedge clk);
        rst  = r;
        stim = v;
        rst_h[n_edges] = r;
        sig_h[n_edges] = v;
        x = expect_at(n_edges, 0);
        q1.push_back(x[0:0]);
        if (x[0]) exp_pulses++;
        q4.push_back(expect_at(n_edges, 2));
        pushed++;
        n_edges++;
    endtask

    // Monitor: output is presented every cycle; compare against queued expectations.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0 && q4.size() > 0) begin
                e1 = q1.pop_front();
                e4 = q4.pop_front();
                popped++;
                if (det1) act_pulses++;
                check($sformatf("w1_fall edge%0d", popped - 1), {3'b000, det1}, {3'b000, e1});
                check($sformatf("w4_both edge%0d", popped - 1), det4, e4);
            end
        end
    end

    initial begin
        // reset hold with sig toggling
        step(1, 4'hF); step(1, 4'h0); step(1, 4'hF);
        // release with sig low: no pulse
        step(0, 4'h0); step(0, 4'h0); step(0, 4'h0);
        // single fall then sustained low
        step(0, 4'h1); step(0, 4'h0);
        repeat (4) step(0, 4'h0);
        // alternating
        for (int i = 0; i < 6; i++) step(0, (i % 2 == 0) ? 4'h1 : 4'h0);
        repeat (3) step(0, 4'h0);
        // lane pattern 1010 -> 0110
        repeat (4) step(0, 4'b1010);
        repeat (5) step(0, 4'b0110);
        // random stream
        for (int i = 0; i < 25; i++) step(0, 4'($urandom_range(0, 15)));
        // reset mid-pulse, then normal detection
        step(0, 4'hF); step(0, 4'h0); step(1, 4'h0); step(0, 4'h0);
        step(0, 4'hF); step(0, 4'hF); step(0, 4'h0);
        repeat (4) step(0, 4'h0);
        // longer random with occasional resets
        for (int i = 0; i < 120; i++)
            step(($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)));
        repeat (4) step(0, 4'h0);

        @(posedge clk);
        #2;
        checks++;
        if (popped == pushed && q1.size() == 0) passed++;
        else $display("FAIL drain: popped %0d, expected %0d", popped, pushed);
        checks++;
        if (act_pulses == exp_pulses) passed++;
        else $display("FAIL pulse_count: got %0d, expected %0d", act_pulses, exp_pulses);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
